// File: rtl/arbitro_registrador_8bits.sv
// Round-robin write arbiter that drives the D input of a shared, enable-less register bank.
// Latency: req edge k -> grant cycle k+1 -> ack/reg_q cycle k+2. req is level-held and never dropped by the arbiter.
module arbitro_registrador_8bits #(
  parameter int N_REQ   = 4,
  parameter int LARGURA = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LARGURA-1:0]   dados,
  input  logic [LARGURA-1:0]         reg_q,
  output logic [LARGURA-1:0]         reg_d,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic                       ocupado,
  output logic [7:0]                 contador_escritas
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } estado_t;

  estado_t              estado;
  estado_t              prox_estado;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     sel_mais_um;
  logic [PTR_W-1:0]     venc_idx;
  logic                 venc_vld;
  logic [LARGURA-1:0]   dado_lat;
  logic [LARGURA-1:0]   dado_venc;

  // Scan from ptr upward with wrap; descending loop so the closest set bit wins.
  always_comb begin
    int idx;
    idx      = 0;
    venc_vld = 1'b0;
    venc_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        venc_vld = 1'b1;
        venc_idx = PTR_W'(idx);
      end
    end
  end

  assign dado_venc   = dados[int'(venc_idx)*LARGURA +: LARGURA];
  assign sel_mais_um = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= IDLE;
    end else begin
      estado <= prox_estado;
    end
  end

  // Outside GRANT the bank's own Q is fed back so it keeps its value.
  always_comb begin
    prox_estado = estado;
    reg_d       = reg_q;
    grant       = '0;
    ack         = '0;
    ocupado     = 1'b0;
    case (estado)
      IDLE: begin
        if (venc_vld) begin
          prox_estado = GRANT;
        end
      end
      GRANT: begin
        prox_estado = ACK;
        reg_d       = dado_lat;
        grant[sel]  = 1'b1;
        ocupado     = 1'b1;
      end
      ACK: begin
        prox_estado = IDLE;
        ack[sel]    = 1'b1;
        ocupado     = 1'b1;
      end
      default: begin
        prox_estado = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr               <= '0;
      sel               <= '0;
      dado_lat          <= '0;
      contador_escritas <= '0;
    end else begin
      case (estado)
        IDLE: begin
          if (venc_vld) begin
            sel      <= venc_idx;
            dado_lat <= dado_venc;
          end
        end
        GRANT: begin
          ptr               <= sel_mais_um;
          contador_escritas <= contador_escritas + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_registrador_8bits.sv
// Bench for arbitro_registrador_8bits: bank model, per-cycle transaction model, directed vectors.
module tb_arbitro_registrador_8bits;

  localparam int N_REQ   = 4;
  localparam int LARGURA = 8;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [N_REQ-1:0]         req   = '0;
  logic [N_REQ*LARGURA-1:0] dados = '0;
  logic [LARGURA-1:0]       reg_q;
  logic [LARGURA-1:0]       reg_d;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         ack;
  logic                     ocupado;
  logic [7:0]               contador_escritas;

  always #5 clock = ~clock;

  arbitro_registrador_8bits #(.N_REQ(N_REQ), .LARGURA(LARGURA)) dut (
    .clock             (clock),
    .reset             (reset),
    .req               (req),
    .dados             (dados),
    .reg_q             (reg_q),
    .reg_d             (reg_d),
    .grant             (grant),
    .ack               (ack),
    .ocupado           (ocupado),
    .contador_escritas (contador_escritas)
  );

  // The shared register bank: no enable, same reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nome, input logic [7:0] atual, input logic [7:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Transaction model: m_age counts edges since the winner was chosen (0 = no write in flight).
  int         m_age  = 0;
  int         m_ptr  = 0;
  int         m_win  = 0;
  int         m_cnt  = 0;
  logic [7:0] m_dat  = '0;
  logic [7:0] m_bank = '0;

  always @(posedge clock or negedge reset) begin
    int  idx;
    bit  achou;
    if (!reset) begin
      m_age = 0; m_ptr = 0; m_win = 0; m_cnt = 0; m_dat = '0; m_bank = '0;
    end else if (m_age == 0) begin
      achou = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (!achou && req[idx]) begin
          achou = 1'b1;
          m_win = idx;
          m_dat = dados[idx*LARGURA +: LARGURA];
          m_age = 1;
        end
      end
    end else if (m_age == 1) begin
      m_bank = m_dat;
      m_cnt  = (m_cnt + 1) % 256;
      m_ptr  = (m_win + 1) % N_REQ;
      m_age  = 2;
    end else begin
      m_age = 0;
    end
  end

  always @(negedge clock) begin
    logic [7:0] eg;
    logic [7:0] ea;
    logic [7:0] ed;
    if (chk_en) begin
      eg = (m_age == 1) ? 8'(1 << m_win) : 8'h00;
      ea = (m_age == 2) ? 8'(1 << m_win) : 8'h00;
      ed = (m_age == 1) ? m_dat : m_bank;
      check("model_grant",    8'(grant),         eg);
      check("model_ack",      8'(ack),           ea);
      check("model_ocupado",  8'(ocupado),       (m_age != 0) ? 8'h01 : 8'h00);
      check("model_reg_d",    reg_d,             ed);
      check("model_reg_q",    reg_q,             m_bank);
      check("model_contador", contador_escritas, 8'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] ordem [5];
    logic [7:0] valor [5];
    ordem = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
    valor = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    chk_en = 1'b1;
    repeat (2) tick();
    reset = 1'b1;

    // Idle after reset
    repeat (10) tick();
    check("rst_reg_q",   reg_q, 8'h00);
    check("rst_reg_d",   reg_d, 8'h00);
    check("rst_grant",   8'(grant), 8'h00);
    check("rst_ack",     8'(ack), 8'h00);
    check("rst_ocupado", 8'(ocupado), 8'h00);
    check("rst_cnt",     contador_escritas, 8'h00);

    // Single write of 0xA5 by requester 0
    dados[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    check("a5_grant", 8'(grant), 8'h01);
    tick();
    check("a5_ack",   8'(ack), 8'h01);
    check("a5_reg_q", reg_q, 8'hA5);
    check("a5_cnt",   contador_escritas, 8'h01);
    req = 4'b0000;
    repeat (20) tick();
    check("a5_hold_reg_q", reg_q, 8'hA5);
    check("a5_hold_ocup",  8'(ocupado), 8'h00);

    // Fresh reset so the rotation starts at requester 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // All four requesting continuously
    dados = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      tick();
      check("rr_grant", 8'(grant), ordem[w]);
      tick();
      check("rr_ack",   8'(ack), ordem[w]);
      check("rr_reg_q", reg_q, valor[w]);
      tick();
    end
    req = 4'b0000;
    check("rr_cnt", contador_escritas, 8'h05);

    // Requester 1 changes its data and drops req during GRANT
    dados[15:8] = 8'h5A;
    req = 4'b0010;
    tick();
    check("late_grant", 8'(grant), 8'h02);
    dados[15:8] = 8'hFF;
    req = 4'b0000;
    tick();
    check("late_ack",   8'(ack), 8'h02);
    check("late_reg_q", reg_q, 8'h5A);
    tick();

    // Pointer is now 2: requests 0 and 1 wrap to 0, then held req goes to 1
    req = 4'b0011;
    tick();
    check("wrap_grant0", 8'(grant), 8'h01);
    tick();
    check("wrap_reg_q0", reg_q, 8'h11);
    tick();
    tick();
    check("wrap_grant1", 8'(grant), 8'h02);
    tick();
    check("wrap_ack1",   8'(ack), 8'h02);
    check("wrap_reg_q1", reg_q, 8'hFF);
    req = 4'b0000;
    tick();

    // Reset pulsed in the middle of a GRANT cycle
    dados[23:16] = 8'h77;
    req = 4'b0100;
    tick();
    check("mid_grant", 8'(grant), 8'h04);
    reset = 1'b0;
    #1;
    check("mid_grant_clr", 8'(grant), 8'h00);
    check("mid_ack_clr",   8'(ack), 8'h00);
    check("mid_ocup_clr",  8'(ocupado), 8'h00);
    check("mid_cnt_clr",   contador_escritas, 8'h00);
    check("mid_reg_q_clr", reg_q, 8'h00);
    req = 4'b0000;
    #1;
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("mid_no_ack", 8'(ack), 8'h00);
    end

    // Counter wrap after 256 writes
    dados[7:0] = 8'h3C;
    req = 4'b0001;
    repeat (255 * 3) tick();
    check("wrap_cnt_255", contador_escritas, 8'hFF);
    repeat (3) tick();
    req = 4'b0000;
    check("wrap_cnt_0",   contador_escritas, 8'h00);
    check("wrap_reg_q",   reg_q, 8'h3C);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
